data_ram_arbiter: RTL
=====================

Name: data_ram_arbiter

Overview:
Shares the single 12-bit-address / 16-bit-data RAM port between the CPU data path (load/store) and an external host port (program loader / debugger). It serialises accesses through a small FSM, applies CPU-first priority with a host starvation guard, and generates a CPU stall so the CPU enable can be held off while its access is pending. The block sits between the CPU data pins and the data RAM.

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 16, RAM data width
RD_LAT, 1, RAM read latency in cycles from the ISSUE cycle to valid memDataIn (legal 1..3)
STARVE_LIM, 4, number of consecutive lost arbitrations after which the host wins

Ports:
clk  in  1  system clock, rising edge
res  in  1  asynchronous, active-low reset
cpuReq  in  1  CPU access request; held until cpuAck
cpuWr  in  1  1 = store, 0 = load
cpuAddr  in  ADDR_W  CPU address
cpuWData  in  DATA_W  CPU store data
cpuRData  out  DATA_W  CPU load data; valid with cpuAck, held until the next CPU load completes
cpuAck  out  1  one-cycle completion pulse
cpuStall  out  1  cpuReq & ~cpuAck (combinational)
hostReq  in  1  host access request; held until hostAck
hostWr  in  1  1 = write, 0 = read
hostClr  in  1  qualifies a host request as a RAM clear; overrides hostWr
hostAddr  in  ADDR_W  host address
hostWData  in  DATA_W  host write data
hostRData  out  DATA_W  host read data; valid with hostAck, held until the next host read completes
hostAck  out  1  one-cycle completion pulse
memAddr  out  ADDR_W  RAM address
memDataOut  out  DATA_W  RAM write data
memDataIn  in  DATA_W  RAM read data
memSel  out  1  RAM select
memLd  out  1  1 = read, 0 = write; meaningful only when memSel = 1
memClr  out  1  RAM clear strobe
busy  out  1  1 whenever the state is not IDLE

Behaviour:
- Reset (res = 0, asynchronous):
  - State goes to IDLE.
  - All registered outputs, cpuRData, hostRData, the latched command registers and the starve counter go to 0.
  - A transaction in flight is aborted with no ack.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE arbitration, evaluated every cycle in IDLE:
  - Only one request present: that requester wins.
  - Both present: the CPU wins, unless starveCnt == STARVE_LIM, in which case the host wins.
  - Winner's op, addr, wdata and owner are latched at the clock edge.
  - Next state is ISSUE. With no request, the state stays IDLE.
- Starve counter:
  - Increments at each IDLE edge where the CPU wins while hostReq = 1.
  - Clears when the host wins, or in any IDLE cycle with hostReq = 0.
  - Saturates at STARVE_LIM.
- ISSUE (exactly one cycle):
  - memAddr and memDataOut are driven from the latched registers; they hold these values through WAIT and DONE and keep the last value in IDLE.
  - Read: memSel = 1, memLd = 1; next state is WAIT.
  - Write: memSel = 1, memLd = 0; next state is DONE.
  - Clear: memSel = 0, memClr = 1; next state is DONE.
- WAIT:
  - Lasts RD_LAT cycles.
  - memDataIn is captured into the owner's RData register at the edge leaving the last WAIT cycle; next state is DONE.
- DONE (one cycle):
  - The owner's ack = 1; then return to IDLE.
  - The non-owner's ack never asserts.
- Latency from a request seen in IDLE to ack:
  - Write / clear: ack in cycle +2.
  - Read: ack in cycle 2 + RD_LAT.
  - Minimum spacing between accesses is one IDLE cycle.
- memSel, memClr and memLd are 0 in every state other than ISSUE.
- Requester deasserts req mid-transaction: the transaction still completes and ack still pulses.
- Requester keeps req high in the cycle after its ack: this is a new request.
- Changes to address or data while not in IDLE are ignored.
- cpuStall stays high from cpuReq until the cpuAck cycle and is low in the ack cycle.

Test Plan:
- CPU store, then load: store to 0x0A5 with data 0xBEEF → memSel=1, memLd=0, memAddr=0x0A5 for one cycle; cpuAck at +2. Load from 0x0A5 with RD_LAT=1 → cpuAck at +3 with cpuRData=0xBEEF; cpuStall high until the ack cycle.
- Host read: RAM preloaded 0x1234 at 0x7FF → hostAck at +3 with hostRData=0x1234; cpuAck stays 0; cpuRData unchanged.
- Contention: cpuReq and hostReq continuously high → CPU granted 4 times, then host once, repeating.
- Host clear (hostReq with hostClr=1): memClr=1 for exactly one cycle, memSel=0, hostAck at +2.
- Reset mid-read (res low during WAIT) → all outputs 0 immediately, no ack; after release, a new CPU load completes normally.
- Parameter sweep, RD_LAT=3: read ack at +5, data captured correctly; hostReq dropped during WAIT → hostAck still pulses once.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// Arbitrates the single data RAM port between the CPU load/store path and the
// host loader/debug port: CPU-first priority with a host starvation guard.
module data_ram_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cpuReq,
  input  logic              cpuWr,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic [DATA_W-1:0] cpuRData,
  output logic              cpuAck,
  output logic              cpuStall,
  input  logic              hostReq,
  input  logic              hostWr,
  input  logic              hostClr,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [DATA_W-1:0] hostWData,
  output logic [DATA_W-1:0] hostRData,
  output logic              hostAck,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataOut,
  input  logic [DATA_W-1:0] memDataIn,
  output logic              memSel,
  output logic              memLd,
  output logic              memClr,
  output logic              busy
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_CLEAR} op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              owner_q, owner_d;   // 1 = host owns the transaction
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_win;

  // NOTE: state registers use non-blocking assignments only; every register
  // here is plain flop state, so all of it is cleared by the async reset.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= S_IDLE;
      op_q         <= OP_READ;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_q     <= '0;
      wait_q       <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_q     <= starve_d;
      wait_q       <= wait_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // NOTE: every signal written below gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_d     = starve_q;
    wait_d       = wait_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    host_win     = 1'b0;

    case (state_q)
      S_IDLE: begin
        host_win = hostReq && (!cpuReq || (starve_q == SW'(STARVE_LIM)));
        if (!hostReq || host_win)
          starve_d = '0;
        else if (starve_q != SW'(STARVE_LIM))
          starve_d = starve_q + SW'(1);
        if (cpuReq || hostReq) begin
          state_d = S_ISSUE;
          owner_d = host_win;
          if (host_win) begin
            op_d    = hostClr ? OP_CLEAR : (hostWr ? OP_WRITE : OP_READ);
            addr_d  = hostAddr;
            wdata_d = hostWData;
          end else begin
            op_d    = cpuWr ? OP_WRITE : OP_READ;
            addr_d  = cpuAddr;
            wdata_d = cpuWData;
          end
        end
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = (op_q == OP_READ) ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (wait_q == WW'(RD_LAT - 1)) begin
          state_d = S_DONE;
          if (owner_q) host_rdata_d = memDataIn;
          else         cpu_rdata_d  = memDataIn;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign memAddr    = addr_q;
  assign memDataOut = wdata_q;
  assign memSel     = (state_q == S_ISSUE) && (op_q != OP_CLEAR);
  assign memLd      = (state_q == S_ISSUE) && (op_q == OP_READ);
  assign memClr     = (state_q == S_ISSUE) && (op_q == OP_CLEAR);
  assign cpuAck     = (state_q == S_DONE) && !owner_q;
  assign hostAck    = (state_q == S_DONE) && owner_q;
  assign cpuStall   = cpuReq && !cpuAck;
  assign busy       = (state_q != S_IDLE);
  assign cpuRData   = cpu_rdata_q;
  assign hostRData  = host_rdata_q;

endmodule
